// File: rtl/param_mem_slave.sv
// Byte-strobed memory slave with a grant FSM and a fixed-latency, fully pipelined read path.
// Optional sticky pattern-match interrupt is enabled by defining PARAM_MEM_SLAVE_INTR_EN.
module param_mem_slave #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       DEPTH     = 256,
  parameter int unsigned       RD_LAT    = 1,
  parameter logic [DATA_W-1:0] MATCH_PAT = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  output logic                gnt,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                rerr,
  output logic                intr,
  input  logic                intr_clr
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [RD_LAT-1:0]   pv;
  logic [RD_LAT-1:0]   pe;
  logic [DATA_W-1:0]   pd [RD_LAT];
  logic                acc_we;
  logic                acc_re;
  logic                rd_ok;
  logic                wr_ok;
  logic [DATA_W-1:0]   rd_word;

  assign acc_we = gnt && we;
  assign acc_re = gnt && re;
  assign rd_ok  = {1'b0, raddr} < DEPTH_W;
  assign wr_ok  = {1'b0, waddr} < DEPTH_W;

  always_comb begin
    rd_word = '0;
    if (rd_ok) rd_word = mem[raddr];
  end

  // Grant FSM; a read accepted in the same cycle req drops counts as in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          state <= GRANT;
          gnt   <= 1'b1;
        end
        GRANT: if (!req) begin
          state <= (acc_re || (|pv)) ? DRAIN : IDLE;
          gnt   <= 1'b0;
        end
        DRAIN: if (!(|pv)) state <= IDLE;
        default: begin
          state <= IDLE;
          gnt   <= 1'b0;
        end
      endcase
    end
  end

  // Read-first: the pipeline captures the word before this edge's write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (acc_we && wr_ok) begin
      for (int unsigned b = 0; b < DATA_W/8; b++)
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  // Data stages only advance with a valid token, so the last stage holds rdata between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      pe <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) pd[i] <= '0;
    end else begin
      pv[0] <= acc_re;
      pe[0] <= acc_re && !rd_ok;
      if (acc_re) pd[0] <= rd_word;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
    end
  end

  assign rvalid = pv[RD_LAT-1];
  assign rerr   = pe[RD_LAT-1];
  assign rdata  = pd[RD_LAT-1];

`ifdef PARAM_MEM_SLAVE_INTR_EN
  logic hit;
  assign hit = rvalid && !rerr && (rdata == MATCH_PAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           intr <= 1'b0;
    else if (hit)      intr <= 1'b1;
    else if (intr_clr) intr <= 1'b0;
  end
`else
  logic unused_intr_clr;
  assign unused_intr_clr = intr_clr;
  assign intr = 1'b0;
`endif

endmodule
